// File: rtl/uart_pkg.sv
// Shared definitions for the UART register bridge: register map, status/control
// layouts and the protocol FSM state encoding.
package uart_pkg;

  localparam logic [2:0] UART_CR_OFFSET    = 3'd0;
  localparam logic [2:0] UART_SR_OFFSET    = 3'd1;
  localparam logic [2:0] UART_DINL_OFFSET  = 3'd2;
  localparam logic [2:0] UART_DINH_OFFSET  = 3'd3;
  localparam logic [2:0] UART_DOUTL_OFFSET = 3'd4;
  localparam logic [2:0] UART_DOUTM_OFFSET = 3'd5;
  localparam logic [2:0] UART_DOUTH_OFFSET = 3'd6;

  typedef struct packed {
    logic [1:0] reserved;
    logic       proto_err;
    logic       sample_overrun;
    logic       fifo_overflow;
    logic       sample_valid;
    logic       tx_fifo_full;
    logic       tx_fifo_empty;
  } uart_sr_t;

  typedef struct packed {
    logic [4:0] reserved;
    logic       clr_sticky;
    logic       flush;
    logic       alg_ce;
  } uart_cr_t;

  typedef enum logic [1:0] {
    StIdle,
    StWdata,
    StResp
  } uart_state_e;

  // Command bytes carry {4'b0, addr[2:0], rw}; anything else is noise.
  function automatic logic uart_cmd_valid(logic [7:0] b);
    return b[7:4] == 4'h0;
  endfunction

endpackage

// File: rtl/rpeak_fifo.sv
// Synchronous FIFO for R-peak locations. Flush beats push; a push into a full FIFO
// only lands if a pop frees a slot in the same cycle.
module rpeak_fifo #(
  parameter int unsigned Width = 22,
  parameter int unsigned Depth = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_o
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned PtrW  = AddrW + 1;

  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);

  assign do_pop     = pop_i && !empty_o && !flush_i;
  assign do_push    = push_i && !flush_i && (!full_o || do_pop);
  assign overflow_o = push_i && !flush_i && full_o && !do_pop;
  assign head_o     = mem_q[rptr_q[AddrW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AddrW-1:0]] <= data_i;
  end

endmodule

// File: rtl/uart_reg_bridge.sv
// Byte-level register protocol between the UART transceiver and the R-peak core:
// command parsing, sample assembly, and R-peak readback through a snapshot register.
module uart_reg_bridge
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 11,
  parameter int unsigned CTR_WIDTH      = 22,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  input  logic [CTR_WIDTH-1:0]  rpeak_loc,
  input  logic                  rpeak_valid,
  output logic                  alg_ce
);

  localparam int unsigned     TmoW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  uart_state_e           state_q;
  logic [2:0]            addr_q;
  logic [TmoW-1:0]       tmo_cnt_q;
  logic [7:0]            tx_data_q;
  logic                  tx_valid_q;
  logic [DATA_WIDTH-1:0] sample_q;
  logic                  sample_valid_q;
  logic                  alg_ce_q;
  logic [7:0]            dinl_q, dinh_q;
  logic [23:0]           snap_q;
  logic                  snap_valid_q;
  logic                  overflow_q, overrun_q, proto_err_q;

  logic                 cmd_stb, cmd_wr, wdata_stb;
  logic [2:0]           cmd_addr;
  logic                 fifo_pop, fifo_flush, fifo_full, fifo_empty, fifo_overflow;
  logic [CTR_WIDTH-1:0] fifo_head;
  logic [23:0]          head_ext;
  uart_sr_t             sr;
  uart_cr_t             cr_rd;
  logic [7:0]           rdata;

  assign cmd_addr   = rx_data[3:1];
  assign cmd_wr     = rx_data[0];
  assign cmd_stb    = (state_q == StIdle) && rx_valid && uart_cmd_valid(rx_data);
  assign wdata_stb  = (state_q == StWdata) && rx_valid;
  assign fifo_flush = wdata_stb && (addr_q == UART_CR_OFFSET) && rx_data[1];
  assign fifo_pop   = cmd_stb && !cmd_wr && (cmd_addr == UART_DOUTH_OFFSET) && snap_valid_q;
  assign head_ext   = 24'(fifo_head);

  rpeak_fifo #(
    .Width (CTR_WIDTH),
    .Depth (FIFO_DEPTH)
  ) u_rpeak_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (rpeak_valid),
    .data_i     (rpeak_loc),
    .pop_i      (fifo_pop),
    .flush_i    (fifo_flush),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .overflow_o (fifo_overflow)
  );

  always_comb begin
    sr                = '0;
    sr.tx_fifo_empty  = fifo_empty;
    sr.tx_fifo_full   = fifo_full;
    sr.sample_valid   = sample_valid_q;
    sr.fifo_overflow  = overflow_q;
    sr.sample_overrun = overrun_q;
    sr.proto_err      = proto_err_q;
    cr_rd             = '0;
    cr_rd.alg_ce      = alg_ce_q;
    case (cmd_addr)
      UART_CR_OFFSET:    rdata = cr_rd;
      UART_SR_OFFSET:    rdata = sr;
      UART_DINL_OFFSET:  rdata = dinl_q;
      UART_DINH_OFFSET:  rdata = dinh_q;
      UART_DOUTL_OFFSET: rdata = fifo_empty ? 8'h00 : head_ext[7:0];
      UART_DOUTM_OFFSET: rdata = snap_q[15:8];
      UART_DOUTH_OFFSET: rdata = snap_q[23:16];
      default:           rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      addr_q         <= '0;
      tmo_cnt_q      <= '0;
      tx_data_q      <= '0;
      tx_valid_q     <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      alg_ce_q       <= 1'b1;
      dinl_q         <= '0;
      dinh_q         <= '0;
      snap_q         <= '0;
      snap_valid_q   <= 1'b0;
      overflow_q     <= 1'b0;
      overrun_q      <= 1'b0;
      proto_err_q    <= 1'b0;
    end else begin
      if (sample_valid_q && sample_ready) sample_valid_q <= 1'b0;
      if (fifo_flush) snap_valid_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (cmd_stb) begin
            addr_q <= cmd_addr;
            if (cmd_wr) begin
              state_q   <= StWdata;
              tmo_cnt_q <= '0;
            end else begin
              state_q    <= StResp;
              tx_data_q  <= rdata;
              tx_valid_q <= 1'b1;
              if (cmd_addr == UART_DOUTL_OFFSET) begin
                snap_q       <= fifo_empty ? 24'h0 : head_ext;
                snap_valid_q <= !fifo_empty;
              end
              if (fifo_pop) snap_valid_q <= 1'b0;
            end
          end
        end
        StWdata: begin
          if (rx_valid) begin
            state_q <= StIdle;
            case (addr_q)
              UART_CR_OFFSET: begin
                alg_ce_q <= rx_data[0];
                if (rx_data[2]) begin
                  overflow_q  <= 1'b0;
                  overrun_q   <= 1'b0;
                  proto_err_q <= 1'b0;
                end
              end
              UART_DINL_OFFSET: dinl_q <= rx_data;
              UART_DINH_OFFSET: begin
                // A pending sample is never overwritten; the new one is lost.
                if (sample_valid_q) begin
                  overrun_q <= 1'b1;
                end else begin
                  dinh_q         <= rx_data;
                  sample_q       <= DATA_WIDTH'({rx_data[2:0], dinl_q});
                  sample_valid_q <= 1'b1;
                end
              end
              default: ;
            endcase
          end else if (tmo_cnt_q == TmoLast) begin
            state_q     <= StIdle;
            proto_err_q <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
          end
        end
        StResp: begin
          if (rx_valid) proto_err_q <= 1'b1;
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Placed after the CR write so a coincident overflow survives a sticky clear.
      if (fifo_overflow) overflow_q <= 1'b1;
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign sample_out   = sample_q;
  assign sample_valid = sample_valid_q;
  assign alg_ce       = alg_ce_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed bench for uart_reg_bridge: a vector table for register/FIFO traffic plus
// hand-written sequences for sample handshake, timeout, RESP and reset corners.
module tb_uart_reg_bridge;

  localparam int unsigned Tmo = 200;
  localparam int KWr = 0, KRd = 1, KPush = 2, KRaw = 3;

  typedef struct {
    int          kind;
    logic [2:0]  addr;
    logic [23:0] data;
    logic [7:0]  exp;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [10:0] sample_out;
  logic        sample_valid;
  logic        sample_ready;
  logic [21:0] rpeak_loc;
  logic        rpeak_valid;
  logic        alg_ce;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_reg_bridge #(
    .DATA_WIDTH     (11),
    .CTR_WIDTH      (22),
    .FIFO_DEPTH     (8),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .rpeak_loc    (rpeak_loc),
    .rpeak_valid  (rpeak_valid),
    .alg_ce       (alg_ce)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(output logic [7:0] v);
    int n;
    n = 0;
    while (!tx_valid && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!tx_valid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL tx_wait: tx_valid got 0, expected 1 within 8 cycles");
      v = 8'hxx;
    end else begin
      v        = tx_data;
      tx_ready = 1'b1;
      @(posedge clk);
      #1;
      tx_ready = 1'b0;
    end
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [7:0] v);
    send_byte({4'h0, a, 1'b0});
    wait_tx(v);
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
    send_byte({4'h0, a, 1'b1});
    send_byte(d);
  endtask

  task automatic push_loc(input logic [21:0] loc);
    rpeak_loc   = loc;
    rpeak_valid = 1'b1;
    @(posedge clk);
    #1;
    rpeak_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[$];
    logic [7:0]  v;
    logic [23:0] e24;

    rst_n        = 1'b0;
    rx_data      = '0;
    rx_valid     = 1'b0;
    tx_ready     = 1'b0;
    sample_ready = 1'b0;
    rpeak_loc    = '0;
    rpeak_valid  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_sample_out", sample_out, 0);
    check("rst_sample_valid", sample_valid, 0);
    check("rst_alg_ce", alg_ce, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Sample assembly with the consumer ready: exactly one valid cycle.
    sample_ready = 1'b1;
    write_reg(3'd2, 8'hF3);
    write_reg(3'd3, 8'h03);
    check("s1_valid", sample_valid, 1);
    check("s1_out", sample_out, 11'h3F3);
    @(posedge clk);
    #1;
    check("s1_valid_drop", sample_valid, 0);
    read_reg(3'd1, v); check("s1_sr", v, 8'h01);
    read_reg(3'd2, v); check("s1_dinl", v, 8'hF3);
    read_reg(3'd3, v); check("s1_dinh", v, 8'h03);

    // Overrun: second sample is dropped while the first is still pending.
    sample_ready = 1'b0;
    write_reg(3'd2, 8'h00);
    write_reg(3'd3, 8'h01);
    write_reg(3'd2, 8'h00);
    write_reg(3'd3, 8'h02);
    check("ovr_out", sample_out, 11'h100);
    check("ovr_valid", sample_valid, 1);
    read_reg(3'd1, v); check("ovr_sr", v, 8'h15);
    sample_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ovr_valid_drop", sample_valid, 0);
    read_reg(3'd1, v); check("ovr_sr_sticky", v, 8'h11);
    write_reg(3'd0, 8'h05);
    read_reg(3'd1, v); check("ovr_sr_clr", v, 8'h01);

    tbl.push_back('{KRd,   3'd1, 24'h0,      8'h01, "tbl_sr_idle"});
    tbl.push_back('{KRd,   3'd0, 24'h0,      8'h01, "tbl_cr_idle"});
    tbl.push_back('{KRaw,  3'd0, 24'hF3,     8'h00, "raw_bad_cmd"});
    tbl.push_back('{KRd,   3'd1, 24'h0,      8'h01, "tbl_sr_after_bad"});
    tbl.push_back('{KWr,   3'd7, 24'hAA,     8'h00, "wr_rsvd"});
    tbl.push_back('{KRd,   3'd7, 24'h0,      8'h00, "tbl_rsvd"});
    tbl.push_back('{KRd,   3'd4, 24'h0,      8'h00, "tbl_doutl_empty"});
    tbl.push_back('{KRd,   3'd6, 24'h0,      8'h00, "tbl_douth_empty"});
    tbl.push_back('{KPush, 3'd0, 24'h12ABCD, 8'h00, "push_a"});
    tbl.push_back('{KPush, 3'd0, 24'h000400, 8'h00, "push_b"});
    tbl.push_back('{KRd,   3'd4, 24'h0,      8'hCD, "tbl_a_l"});
    tbl.push_back('{KRd,   3'd5, 24'h0,      8'hAB, "tbl_a_m"});
    tbl.push_back('{KRd,   3'd6, 24'h0,      8'h12, "tbl_a_h"});
    tbl.push_back('{KRd,   3'd4, 24'h0,      8'h00, "tbl_b_l"});
    tbl.push_back('{KRd,   3'd5, 24'h0,      8'h04, "tbl_b_m"});
    tbl.push_back('{KRd,   3'd6, 24'h0,      8'h00, "tbl_b_h"});
    tbl.push_back('{KRd,   3'd1, 24'h0,      8'h01, "tbl_sr_drained"});
    tbl.push_back('{KWr,   3'd0, 24'h00,     8'h00, "wr_cr_off"});
    tbl.push_back('{KRd,   3'd0, 24'h0,      8'h00, "tbl_cr_off"});
    tbl.push_back('{KWr,   3'd0, 24'h07,     8'h00, "wr_cr_all"});
    tbl.push_back('{KRd,   3'd0, 24'h0,      8'h01, "tbl_cr_selfclr"});

    foreach (tbl[i]) begin
      case (tbl[i].kind)
        KWr:     write_reg(tbl[i].addr, tbl[i].data[7:0]);
        KPush:   push_loc(tbl[i].data[21:0]);
        KRaw:    send_byte(tbl[i].data[7:0]);
        default: begin
          read_reg(tbl[i].addr, v);
          check(tbl[i].name, v, tbl[i].exp);
        end
      endcase
    end

    // Nine pushes into eight slots: last is lost, overflow sticks.
    for (int i = 1; i <= 9; i++) push_loc(22'(i * 32'h011111));
    read_reg(3'd1, v); check("ovf_sr", v, 8'h0A);
    for (int i = 1; i <= 8; i++) begin
      e24 = 24'(i * 32'h011111);
      read_reg(3'd4, v); check($sformatf("ovf_e%0d_l", i), v, e24[7:0]);
      read_reg(3'd5, v); check($sformatf("ovf_e%0d_m", i), v, e24[15:8]);
      read_reg(3'd6, v); check($sformatf("ovf_e%0d_h", i), v, e24[23:16]);
    end
    read_reg(3'd1, v); check("ovf_sr_empty", v, 8'h09);
    write_reg(3'd0, 8'h05);
    read_reg(3'd1, v); check("ovf_sr_clr", v, 8'h01);

    // Push and pop in the same cycle while full: no overflow, stays full.
    for (int i = 1; i <= 8; i++) push_loc(22'(32'h100 + i));
    read_reg(3'd4, v); check("fp_l", v, 8'h01);
    read_reg(3'd5, v); check("fp_m", v, 8'h01);
    rpeak_loc   = 22'h3FFFFF;
    rpeak_valid = 1'b1;
    send_byte(8'h0C);
    rpeak_valid = 1'b0;
    wait_tx(v); check("fp_h", v, 8'h00);
    read_reg(3'd1, v); check("fp_sr_full", v, 8'h02);

    // Flush coincident with a push: flush wins, no overflow.
    send_byte(8'h01);
    rx_data     = 8'h03;
    rx_valid    = 1'b1;
    rpeak_loc   = 22'h000055;
    rpeak_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid    = 1'b0;
    rpeak_valid = 1'b0;
    read_reg(3'd1, v); check("flush_sr", v, 8'h01);
    read_reg(3'd4, v); check("flush_doutl", v, 8'h00);

    // Byte arriving during RESP is dropped and flagged.
    send_byte(8'h02);
    check("resp_latency", tx_valid, 1);
    check("resp_data", tx_data, 8'h01);
    send_byte(8'h0B);
    check("resp_hold", tx_valid, 1);
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    check("resp_release", tx_valid, 0);
    read_reg(3'd1, v); check("resp_sr_proto", v, 8'h21);
    write_reg(3'd0, 8'h05);

    // Data byte on the last allowed cycle is still accepted.
    send_byte(8'h05);
    repeat (Tmo - 1) @(posedge clk);
    #1;
    send_byte(8'h77);
    read_reg(3'd2, v); check("tmo_edge_dinl", v, 8'h77);
    read_reg(3'd1, v); check("tmo_edge_sr", v, 8'h01);

    // Abandoned write: aborted after Tmo idle cycles.
    send_byte(8'h05);
    repeat (Tmo) @(posedge clk);
    #1;
    read_reg(3'd1, v); check("tmo_sr", v, 8'h21);
    write_reg(3'd3, 8'h06);
    check("tmo_sample", sample_out, 11'h677);

    // Asynchronous reset in the middle of a pending response.
    write_reg(3'd0, 8'h00);
    check("pre_rst_alg_ce", alg_ce, 0);
    push_loc(22'h0ABCDE);
    send_byte(8'h00);
    check("pre_rst_tx_valid", tx_valid, 1);
    rst_n = 1'b0;
    #1;
    check("arst_tx_valid", tx_valid, 0);
    check("arst_tx_data", tx_data, 0);
    check("arst_alg_ce", alg_ce, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    read_reg(3'd0, v); check("post_rst_cr", v, 8'h01);
    read_reg(3'd1, v); check("post_rst_sr", v, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
